ramif_nibble_responder: RTL and testbench
=========================================

// Module: ramif_nibble_responder
// PURPOSE
//  Target end of the nibble-serial RAM interface. Receives a WORD_BITS-wide address
//  over RAM_PINS pins in RAM_CYCLES beats, LS nibble first. Then returns the addressed
//  word over the same number of beats, LS nibble first. Runs in lockstep with the
//  initiator from a common reset. Used as an on-chip RAM model and as a loopback target.
// PARAMETERS
//  RAM_LOG2_CYCLES  2  log2 of beats per phase; RAM_CYCLES = 2**RAM_LOG2_CYCLES
//  RAM_PINS         4  pins per beat; WORD_BITS = RAM_PINS*RAM_CYCLES (16)
//  MEM_ADDR_BITS    6  storage depth 2**MEM_ADDR_BITS words
// PORTS
//  clk        in   1              clock
//  rst_n      in   1              asynchronous reset, active low
//  sync       in   1              synchronous resync: force beat 0 of ADDR phase
//  addr_bits  in   RAM_PINS       address nibble from initiator
//  data_bits  out  RAM_PINS       data nibble to initiator
//  wr_en      in   1              preload write strobe (RAMIF_RESP_WRPORT_EN only)
//  wr_addr    in   MEM_ADDR_BITS  preload write address (RAMIF_RESP_WRPORT_EN only)
//  wr_data    in   WORD_BITS      preload write data (RAMIF_RESP_WRPORT_EN only)
//  phase      out  1              0 = ADDR, 1 = DATA
//  beat       out  RAM_LOG2_CYCLES  current beat index
// BEHAVIOUR
//  - Reset (async): beat=0, phase=ADDR, addr_sr=0, rd_word=0; data_bits=0.
//  - beat increments every clk and wraps RAM_CYCLES-1 -> 0. phase toggles on each wrap.
//    This matches the initiator counter/state exactly.
//  - ADDR phase, beat k<last: addr_sr[k*RAM_PINS +: RAM_PINS] <= addr_bits.
//  - ADDR phase, last beat: form full = {addr_bits, addr_sr[lower bits]}. Then
//    rd_word <= mem[full[MEM_ADDR_BITS-1:0]]. Upper address bits are ignored,
//    so the array aliases.
//  - DATA phase, beat k: data_bits = rd_word[k*RAM_PINS +: RAM_PINS]. This is
//    combinational from registers, with zero wait beats. The initiator samples it
//    on the edge that ends beat k.
//  - ADDR phase: data_bits = 0.
//  - Latency: word is valid from beat 0 of DATA, one clk after the last address nibble.
//  - sync=1 (any phase/beat): next state beat=0, phase=ADDR. The partial address is
//    discarded and rd_word is held. sync has priority over normal advance.
//  - Reset mid-transaction: transfer abandoned. Memory contents are not reset.
//  - Write and read of the same word on the same edge: the read returns the OLD word.
//    The write lands.
//  - Writes are accepted in any phase and do not disturb beat/phase.
// CONFIGURATION
//  RAMIF_RESP_WRPORT_EN defined: 2**MEM_ADDR_BITS x WORD_BITS flop array, written
//    via wr_*. Array contents are undefined until written.
//  RAMIF_RESP_WRPORT_EN undefined: no storage and wr_* are ignored.
//    rd_word <= ramif_pattern(full) = full ^ {full[7:0], full[15:8]} ^ 16'hA5C3.
//    This holds for any WORD_BITS, by truncation and extension of the pattern.
// STRUCTURE
//  - ramif_pkg holds the shared items:
//    - RAM_LOG2_CYCLES / RAM_PINS defaults
//    - phase constants PHASE_ADDR=0 and PHASE_DATA=1
//    - function ramif_pattern
//    - nibble-select helper
//  - Sub-module ramif_resp_mem: flop array with a write port and a registered read
//    (rd_en, rd_addr, rd_word). It is instantiated only under RAMIF_RESP_WRPORT_EN.
//  - Top level: beat/phase counter, addr shift register, data_bits mux.
// TESTING
//  1. Reset then free-run with addr_bits=0 -> phase toggles every 4 clks.
//     data_bits=0 throughout ADDR; beat sequence 0,1,2,3,0.
//  2. WRPORT_EN: write mem[5]=16'hBEEF. Drive nibbles 5,0,0,0 -> DATA beats
//     return F,E,E,B.
//  3. Address 16'h1245 (MEM_ADDR_BITS=6) -> returns mem[5], showing alias.
//     No macro: addr 16'h0000 -> DATA nibbles 3,C,5,A.
//  4. Assert sync during ADDR beat 2 -> next clk beat=0/ADDR. Old partial address
//     is discarded and a new address is honoured.
//  5. Write mem[5]=16'h1111 on the last-ADDR-beat edge while reading 5. This cycle
//     returns the old 16'hBEEF; the next transaction returns 16'h1111.
//  6. Pair with the initiator (common reset): for each address a, the initiator
//     data register equals the model word every transaction. Includes a mid-DATA
//     rst_n pulse; both sides restart aligned.

Source files
------------

// File: rtl/ramif_pkg.sv
// ramif_pkg: shared defaults, phase encoding and helpers for the nibble-serial RAM interface
package ramif_pkg;
  localparam int RAM_LOG2_CYCLES_DEF = 2;
  localparam int RAM_PINS_DEF = 4;
  typedef enum logic {PHASE_ADDR = 1'b0, PHASE_DATA = 1'b1} phase_e;
  function automatic logic [15:0] ramif_pattern(input logic [15:0] full);
    return full ^ {full[7:0], full[15:8]} ^ 16'hA5C3;
  endfunction
  function automatic int nib_lsb(input int k, input int pins);
    return k * pins;
  endfunction
endpackage

// File: rtl/ramif_resp_mem.sv
// ramif_resp_mem: flop word array with one write port and a registered read port
// Ports: clk, rst_n (async, active low, clears rd_word only), wr_en/wr_addr/wr_data
// write port, rd_en/rd_addr read request, rd_word registered read data.
// Only built when RAMIF_RESP_WRPORT_EN is defined.
`ifdef RAMIF_RESP_WRPORT_EN
module ramif_resp_mem #(
  parameter int ADDR_BITS = 6,
  parameter int WORD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WORD_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WORD_BITS-1:0] rd_word
);
  logic [WORD_BITS-1:0] mem [2**ADDR_BITS];
  // Contents are deliberately not reset; a same-edge read sees the old word.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_word <= '0;
    else if (rd_en) rd_word <= mem[rd_addr];
endmodule
`endif

// File: rtl/ramif_nibble_responder.sv
// ramif_nibble_responder: target end of the nibble-serial RAM interface
// Ports: clk, rst_n (async, active low), sync (resync to ADDR beat 0),
// addr_bits (address nibble in), data_bits (data nibble out),
// wr_en/wr_addr/wr_data (preload port, used only with RAMIF_RESP_WRPORT_EN),
// phase (0 ADDR, 1 DATA), beat (beat index within the phase).
// RAMIF_RESP_WRPORT_EN defined: words come from a writable flop array.
// Undefined: words come from ramif_pattern of the received address.
module ramif_nibble_responder
  import ramif_pkg::*;
#(
  parameter int RAM_LOG2_CYCLES = RAM_LOG2_CYCLES_DEF,
  parameter int RAM_PINS = RAM_PINS_DEF,
  parameter int MEM_ADDR_BITS = 6,
  localparam int WORD_BITS = RAM_PINS << RAM_LOG2_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sync,
  input  logic [RAM_PINS-1:0]        addr_bits,
  output logic [RAM_PINS-1:0]        data_bits,
  input  logic                       wr_en,
  input  logic [MEM_ADDR_BITS-1:0]   wr_addr,
  input  logic [WORD_BITS-1:0]       wr_data,
  output logic                       phase,
  output logic [RAM_LOG2_CYCLES-1:0] beat
);
  localparam int LW = WORD_BITS - RAM_PINS;
  logic [RAM_LOG2_CYCLES-1:0] beat_q;
  phase_e phase_q;
  logic [LW-1:0] addr_sr;
  logic [WORD_BITS-1:0] full, rd_word;
  logic last, rd_en;
  assign last = &beat_q;
  assign rd_en = !sync && phase_q == PHASE_ADDR && last;
  // The final nibble is used straight off the pins, so it is never stored.
  assign full = {addr_bits, addr_sr};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat_q <= '0;
      phase_q <= PHASE_ADDR;
      addr_sr <= '0;
    end else if (sync) begin
      beat_q <= '0;
      phase_q <= PHASE_ADDR;
      addr_sr <= '0;
    end else begin
      beat_q <= beat_q + 1'b1;
      if (last) phase_q <= phase_q == PHASE_ADDR ? PHASE_DATA : PHASE_ADDR;
      if (phase_q == PHASE_ADDR && !last)
        addr_sr[nib_lsb(int'(beat_q), RAM_PINS) +: RAM_PINS] <= addr_bits;
    end
`ifdef RAMIF_RESP_WRPORT_EN
  logic unused_full;
  assign unused_full = ^full[WORD_BITS-1:MEM_ADDR_BITS];
  ramif_resp_mem #(.ADDR_BITS(MEM_ADDR_BITS), .WORD_BITS(WORD_BITS)) u_mem (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .rd_addr(full[MEM_ADDR_BITS-1:0]),
    .rd_word(rd_word)
  );
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  // The pattern is defined on 16 bits; other word widths truncate or zero-extend it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_word <= '0;
    else if (rd_en) rd_word <= WORD_BITS'(ramif_pattern(16'(full)));
`endif
  assign data_bits = phase_q == PHASE_DATA ? rd_word[nib_lsb(int'(beat_q), RAM_PINS) +: RAM_PINS] : '0;
  assign phase = phase_q;
  assign beat = beat_q;
endmodule

// File: tb/tb_ramif_nibble_responder.sv
// tb_ramif_nibble_responder: directed self-checking bench for ramif_nibble_responder
module tb_ramif_nibble_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync = 1'b0;
  logic [3:0] addr_bits = '0;
  logic [3:0] data_bits;
  logic wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic phase;
  logic [1:0] beat;
  int total = 0;
  int bad = 0;
  logic [15:0] got;

`ifdef RAMIF_RESP_WRPORT_EN
  localparam logic [15:0] EXP_5 = 16'hBEEF;
  localparam logic [15:0] EXP_ALIAS = 16'hBEEF;
  localparam logic [15:0] EXP_5_NEW = 16'h1111;
`else
  localparam logic [15:0] EXP_5 = 16'hA0C6;
  localparam logic [15:0] EXP_ALIAS = 16'hF294;
  localparam logic [15:0] EXP_5_NEW = 16'hA0C6;
`endif

  ramif_nibble_responder dut (
    .clk(clk),
    .rst_n(rst_n),
    .sync(sync),
    .addr_bits(addr_bits),
    .data_bits(data_bits),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .phase(phase),
    .beat(beat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends at ADDR beat 0; optional write lands on the last-ADDR-beat edge.
  task automatic xact(input logic [15:0] a, input logic wr, input logic [15:0] wd, output logic [15:0] w);
    for (int k = 0; k < 4; k++) begin
      addr_bits = a[k*4 +: 4];
      if (k == 3 && wr) begin
        wr_en = 1'b1;
        wr_addr = 6'd5;
        wr_data = wd;
      end
      tick();
      wr_en = 1'b0;
    end
    addr_bits = '0;
    check("data_phase", {31'd0, phase}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      w[k*4 +: 4] = data_bits;
      tick();
    end
    check("back_to_addr", {30'd0, beat, phase}, 32'd0);
  endtask

  initial begin
    #3;
    check("rst_beat", {30'd0, beat}, 32'd0);
    check("rst_phase", {31'd0, phase}, 32'd0);
    check("rst_data", {28'd0, data_bits}, 32'd0);
    #9 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = i == 0;
      wr_addr = 6'd5;
      wr_data = 16'hBEEF;
      check("run_beat", {30'd0, beat}, 32'(i % 4));
      check("run_phase", {31'd0, phase}, 32'((i / 4) % 2));
      if (i < 4) check("addr_data_zero", {28'd0, data_bits}, 32'd0);
      tick();
    end
    wr_en = 1'b0;
    check("wrap_beat", {30'd0, beat, phase}, 32'd0);
    xact(16'h0005, 1'b0, 16'h0, got);
    check("word_5", {16'd0, got}, {16'd0, EXP_5});
    xact(16'h1245, 1'b0, 16'h0, got);
    check("word_alias", {16'd0, got}, {16'd0, EXP_ALIAS});
`ifndef RAMIF_RESP_WRPORT_EN
    xact(16'h0000, 1'b0, 16'h0, got);
    check("pattern_0", {16'd0, got}, 32'h0000A5C3);
    xact(16'h00FF, 1'b0, 16'h0, got);
    check("pattern_ff", {16'd0, got}, 32'h00005A3C);
    xact(16'hFFFF, 1'b0, 16'h0, got);
    check("pattern_ffff", {16'd0, got}, 32'h0000A5C3);
`endif
    addr_bits = 4'hF;
    tick();
    tick();
    sync = 1'b1;
    check("pre_sync_beat", {30'd0, beat}, 32'd2);
    tick();
    sync = 1'b0;
    check("sync_state", {30'd0, beat, phase}, 32'd0);
    xact(16'h0005, 1'b0, 16'h0, got);
    check("after_sync", {16'd0, got}, {16'd0, EXP_5});
    xact(16'h0005, 1'b0, 16'h0, got);
    repeat (5) tick();
    check("data_beat1", {30'd0, beat, phase}, 32'd3);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_from_data", {28'd0, data_bits, beat, phase}, 32'd0);
    xact(16'h0005, 1'b1, 16'h1111, got);
    check("same_edge_old", {16'd0, got}, {16'd0, EXP_5});
    xact(16'h0005, 1'b0, 16'h0, got);
    check("write_landed", {16'd0, got}, {16'd0, EXP_5_NEW});
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst", {28'd0, data_bits, beat, phase}, 32'd0);
    #2 rst_n = 1'b1;
    xact(16'h0005, 1'b0, 16'h0, got);
    check("post_rst_word", {16'd0, got}, {16'd0, EXP_5_NEW});
    xact(16'h1245, 1'b0, 16'h0, got);
    check("post_rst_alias", {16'd0, got}, {16'd0, EXP_5_NEW == 16'h1111 ? 16'h1111 : 16'hF294});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
